tpg_pattern_sequencer: RTL and testbench

Control block that drives the 8-bit pattern select input of the sync/pattern test-pattern generator.
- Accepts host commands over a valid/ready interface.
- Applies pattern changes only on frame boundaries, using the generator's frame-end pulse, so no frame ever shows two patterns.
- Supports a manual mode and an auto-cycle mode: steps through a programmable slot table, holding each entry for a programmable number of frames.
- Sits between the host/config logic and the generator top; pattern_o connects to the generator's pattern input.

---
 rtl/tpg_seq_pkg.sv | 27 ++
 rtl/tpg_pattern_sequencer_if.sv | 23 ++
 rtl/tpg_slot_table.sv | 32 +++
 rtl/tpg_pattern_sequencer.sv | 169 ++++++++++++++++
 tb/tb_tpg_pattern_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tpg_seq_pkg.sv
// Shared encodings and defaults for the test-pattern sequencer.
package tpg_seq_pkg;

  localparam int PAT_W     = 8;
  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;
  localparam int DWELL_W   = 8;
  localparam int FCNT_W    = 16;

  // Ramp pattern shown after reset.
  localparam logic [7:0] RESET_PATTERN_DEF = 8'd4;

  typedef enum logic [1:0] {
    OP_SET    = 2'd0,
    OP_WRSLOT = 2'd1,
    OP_START  = 2'd2,
    OP_STOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_MAN  = 2'd0,
    ST_PEND = 2'd1,
    ST_ARM  = 2'd2,
    ST_AUTO = 2'd3
  } state_e;

endpackage

// File: rtl/tpg_pattern_sequencer_if.sv
// Host command channel (valid/ready) into the pattern sequencer.
interface tpg_pattern_sequencer_if #(
  parameter int PAT_W  = 8,
  parameter int SLOT_W = 3
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_op;
  logic [SLOT_W-1:0] cfg_addr;
  logic [PAT_W-1:0]  cfg_data;

  modport master (
    output cfg_valid, cfg_op, cfg_addr, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_addr, cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/tpg_slot_table.sv
// Auto-cycle slot table: synchronous write, asynchronous read, synchronous clear.
// The read port returns the pre-write contents when a write hits the same slot.
module tpg_slot_table #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int PAT_W     = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              we,
  input  logic [SLOT_W-1:0] waddr,
  input  logic [PAT_W-1:0]  wdata,
  input  logic [SLOT_W-1:0] raddr,
  output logic [PAT_W-1:0]  rdata
);

  logic [PAT_W-1:0] mem_r [NUM_SLOTS];

  // Table storage: cleared by reset, otherwise written on command.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/tpg_pattern_sequencer.sv
// Drives the generator's pattern select; changes only land on frame boundaries.
module tpg_pattern_sequencer
  import tpg_seq_pkg::*;
#(
  parameter int               PAT_W         = 8,
  parameter int               NUM_SLOTS     = 8,
  parameter int               SLOT_W        = 3,
  parameter int               DWELL_W       = 8,
  parameter logic [PAT_W-1:0] RESET_PATTERN = 8'd4,
  parameter int               FCNT_W        = 16
) (
  input  logic                          clk_i,
  input  logic                          resetb_i,
  input  logic                          frame_end_i,
  tpg_pattern_sequencer_if.slave        cfg,
  output logic [PAT_W-1:0]              pattern_o,
  output logic                          pattern_upd_o,
  output logic                          auto_active_o,
  output logic [SLOT_W-1:0]             slot_idx_o,
  output logic [FCNT_W-1:0]             frame_cnt_o
);

  state_e              state_r, state_nxt_s;
  logic [PAT_W-1:0]    pattern_r, pattern_nxt_s;
  logic                upd_r, upd_nxt_s;
  logic [SLOT_W-1:0]   slot_r, slot_nxt_s, next_slot_s;
  logic [DWELL_W-1:0]  cnt_r, cnt_nxt_s;
  logic [DWELL_W-1:0]  dwell_r, dwell_nxt_s;
  logic [SLOT_W-1:0]   last_r, last_nxt_s;
  logic [PAT_W-1:0]    pend_r, pend_nxt_s;
  logic [FCNT_W-1:0]   fcnt_r;
  logic                accept_s;
  logic                tbl_we_s;
  logic [SLOT_W-1:0]   tbl_raddr_s;
  logic [PAT_W-1:0]    tbl_rdata_s;

  assign cfg.cfg_ready = (state_r == ST_MAN) || (state_r == ST_AUTO);
  assign accept_s      = cfg.cfg_valid && cfg.cfg_ready;

  // Wrap back to slot 0 after the last programmed slot.
  assign next_slot_s = (slot_r == last_r) ? '0 : slot_r + SLOT_W'(1);
  // Arming always loads slot 0; auto mode looks ahead to the next slot.
  assign tbl_raddr_s = (state_r == ST_ARM) ? '0 : next_slot_s;

  tpg_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W),
    .PAT_W     (PAT_W)
  ) u_table (
    .clk    (clk_i),
    .resetb (resetb_i),
    .we     (tbl_we_s),
    .waddr  (cfg.cfg_addr),
    .wdata  (cfg.cfg_data),
    .raddr  (tbl_raddr_s),
    .rdata  (tbl_rdata_s)
  );

  // Next-state: frame-end work uses pre-command registers, then the command applies.
  always_comb begin
    state_nxt_s   = state_r;
    pattern_nxt_s = pattern_r;
    upd_nxt_s     = 1'b0;
    slot_nxt_s    = slot_r;
    cnt_nxt_s     = cnt_r;
    dwell_nxt_s   = dwell_r;
    last_nxt_s    = last_r;
    pend_nxt_s    = pend_r;
    tbl_we_s      = 1'b0;

    if (frame_end_i) begin
      case (state_r)
        ST_PEND: begin
          pattern_nxt_s = pend_r;
          upd_nxt_s     = 1'b1;
          state_nxt_s   = ST_MAN;
        end
        ST_ARM: begin
          pattern_nxt_s = tbl_rdata_s;
          slot_nxt_s    = '0;
          cnt_nxt_s     = dwell_r - DWELL_W'(1);
          upd_nxt_s     = 1'b1;
          state_nxt_s   = ST_AUTO;
        end
        ST_AUTO: begin
          if (cnt_r == '0) begin
            slot_nxt_s    = next_slot_s;
            pattern_nxt_s = tbl_rdata_s;
            cnt_nxt_s     = dwell_r - DWELL_W'(1);
            upd_nxt_s     = 1'b1;
          end else begin
            cnt_nxt_s     = cnt_r - DWELL_W'(1);
          end
        end
        default: begin
          upd_nxt_s = 1'b0;
        end
      endcase
    end else begin
      upd_nxt_s = 1'b0;
    end

    if (accept_s) begin
      case (op_e'(cfg.cfg_op))
        OP_SET: begin
          pend_nxt_s  = cfg.cfg_data;
          state_nxt_s = ST_PEND;
        end
        OP_WRSLOT: begin
          tbl_we_s = 1'b1;
        end
        OP_START: begin
          last_nxt_s  = cfg.cfg_addr;
          // A dwell of zero frames would never advance; treat it as one.
          dwell_nxt_s = (cfg.cfg_data[DWELL_W-1:0] == '0) ? DWELL_W'(1)
                                                          : cfg.cfg_data[DWELL_W-1:0];
          state_nxt_s = ST_ARM;
        end
        OP_STOP: begin
          state_nxt_s = ST_MAN;
        end
        default: begin
          state_nxt_s = state_nxt_s;
        end
      endcase
    end else begin
      tbl_we_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state_r <= ST_MAN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: visible outputs plus command parameters.
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      pattern_r <= RESET_PATTERN;
      upd_r     <= 1'b0;
      slot_r    <= '0;
      cnt_r     <= '0;
      dwell_r   <= '0;
      last_r    <= '0;
      pend_r    <= '0;
      fcnt_r    <= '0;
    end else begin
      pattern_r <= pattern_nxt_s;
      upd_r     <= upd_nxt_s;
      slot_r    <= slot_nxt_s;
      cnt_r     <= cnt_nxt_s;
      dwell_r   <= dwell_nxt_s;
      last_r    <= last_nxt_s;
      pend_r    <= pend_nxt_s;
      fcnt_r    <= frame_end_i ? fcnt_r + FCNT_W'(1) : fcnt_r;
    end
  end

  assign pattern_o     = pattern_r;
  assign pattern_upd_o = upd_r;
  assign slot_idx_o    = slot_r;
  assign frame_cnt_o   = fcnt_r;
  assign auto_active_o = (state_r == ST_ARM) || (state_r == ST_AUTO);

endmodule

// File: tb/tb_tpg_pattern_sequencer.sv
// Randomised bench with a frame-level reference model and an update scoreboard.
module tb_tpg_pattern_sequencer;
  import tpg_seq_pkg::*;

  logic        clk = 1'b0;
  logic        resetb;
  logic        frame_end;
  logic [7:0]  pattern;
  logic        pattern_upd;
  logic        auto_active;
  logic [2:0]  slot_idx;
  logic [15:0] frame_cnt;

  tpg_pattern_sequencer_if cfg_if ();

  tpg_pattern_sequencer dut (
    .clk_i         (clk),
    .resetb_i      (resetb),
    .frame_end_i   (frame_end),
    .cfg           (cfg_if.slave),
    .pattern_o     (pattern),
    .pattern_upd_o (pattern_upd),
    .auto_active_o (auto_active),
    .slot_idx_o    (slot_idx),
    .frame_cnt_o   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected pattern for each update pulse, in order.
  logic [7:0] exp_q [$];

  // Reference model, described in frames rather than counter states.
  logic [7:0]  m_table [8];
  logic [7:0]  m_pattern;
  logic [15:0] m_fcnt;
  bit          m_pending, m_arming, m_auto;
  logic [7:0]  m_pend;
  int          m_slot, m_last, m_dwell, m_frames_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_table[i] = 8'd0;
    m_pattern = 8'd4;
    m_fcnt    = 16'd0;
    m_pending = 1'b0;
    m_arming  = 1'b0;
    m_auto    = 1'b0;
    m_pend    = 8'd0;
    m_slot    = 0;
    m_last    = 0;
    m_dwell   = 1;
    m_frames_left = 0;
  endtask

  function automatic bit model_ready();
    return !m_pending && !m_arming;
  endfunction

  task automatic model_step(input bit fe, input bit acc, input logic [1:0] op,
                            input logic [2:0] a, input logic [7:0] d);
    if (fe) begin
      m_fcnt = m_fcnt + 16'd1;
      if (m_pending) begin
        m_pattern = m_pend;
        m_pending = 1'b0;
        exp_q.push_back(m_pattern);
      end else if (m_arming) begin
        m_slot = 0;
        m_pattern = m_table[0];
        m_frames_left = m_dwell;
        m_arming = 1'b0;
        m_auto = 1'b1;
        exp_q.push_back(m_pattern);
      end else if (m_auto) begin
        m_frames_left--;
        if (m_frames_left == 0) begin
          m_slot = (m_slot + 1) % (m_last + 1);
          m_pattern = m_table[m_slot];
          m_frames_left = m_dwell;
          exp_q.push_back(m_pattern);
        end
      end
    end
    if (acc) begin
      case (op)
        2'd0: begin m_pend = d; m_pending = 1'b1; m_auto = 1'b0; end
        2'd1: m_table[a] = d;
        2'd2: begin m_last = int'(a); m_dwell = (d == 8'd0) ? 1 : int'(d);
                    m_arming = 1'b1; m_auto = 1'b0; end
        default: m_auto = 1'b0;
      endcase
    end
  endtask

  // One clock: check settled outputs against the model, then drive the next inputs.
  task automatic cyc(input bit fe, input bit v, input logic [1:0] op,
                     input logic [2:0] a, input logic [7:0] d, input bit rst = 1'b0);
    bit acc;
    @(posedge clk); #1;
    check("pattern", pattern, m_pattern);
    check("frame_cnt", frame_cnt, m_fcnt);
    check("auto_active", auto_active, m_arming || m_auto);
    check("cfg_ready", cfg_if.cfg_ready, model_ready());
    check("slot_idx", slot_idx, m_slot[2:0]);
    resetb = !rst;
    frame_end = fe;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_op = op;
    cfg_if.cfg_addr = a;
    cfg_if.cfg_data = d;
    if (rst) begin
      model_reset();
    end else begin
      acc = v && model_ready();
      model_step(fe, acc, op, a, d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
  endtask

  task automatic frame(input int n_idle);
    idle(n_idle);
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
  endtask

  // Monitor: every update pulse must match the next expected pattern.
  always @(negedge clk) begin
    if (pattern_upd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL upd_spurious: got pulse with pattern %0h expected no pulse at %0t",
                 pattern, $time);
      end else begin
        check("upd_pattern", pattern, exp_q.pop_front());
      end
    end
  end

  initial begin
    int gap;
    resetb = 1'b0;
    frame_end = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_op = 2'd0;
    cfg_if.cfg_addr = 3'd0;
    cfg_if.cfg_data = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;

    // Idle frames after reset.
    repeat (3) frame(3);
    idle(2);

    // SET mid-frame, applied at the next frame end.
    cyc(1'b0, 1'b1, OP_SET, 3'd0, 8'd1);
    idle(3);
    frame(0);
    idle(2);

    // Three-slot table, dwell 2.
    cyc(1'b0, 1'b1, OP_WRSLOT, 3'd0, 8'd1);
    cyc(1'b0, 1'b1, OP_WRSLOT, 3'd1, 8'd2);
    cyc(1'b0, 1'b1, OP_WRSLOT, 3'd2, 8'd4);
    cyc(1'b0, 1'b1, OP_START, 3'd2, 8'd2);
    repeat (7) frame(4);

    // SET together with a frame end while in auto mode.
    cyc(1'b1, 1'b1, OP_SET, 3'd0, 8'd0);
    frame(3);
    idle(2);

    // STOP mid-dwell freezes the pattern.
    cyc(1'b0, 1'b1, OP_START, 3'd2, 8'd3);
    frame(2);
    frame(2);
    cyc(1'b0, 1'b1, OP_STOP, 3'd0, 8'd0);
    repeat (4) frame(2);

    // last=0 with dwell 0: slot 0 reloads every frame.
    cyc(1'b0, 1'b1, OP_START, 3'd0, 8'd0);
    repeat (3) frame(2);

    // Write into the slot being loaded on the same frame end.
    cyc(1'b0, 1'b1, OP_START, 3'd1, 8'd1);
    frame(2);
    cyc(1'b1, 1'b1, OP_WRSLOT, 3'd1, 8'hAA);
    repeat (3) frame(2);
    cyc(1'b0, 1'b1, OP_STOP, 3'd0, 8'd0);

    // Reset while a SET is pending.
    cyc(1'b0, 1'b1, OP_SET, 3'd0, 8'd3);
    idle(1);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    frame(2);
    idle(2);

    // Randomised traffic.
    gap = $urandom_range(3, 12);
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] op;
      logic [7:0] d;
      bit fe;
      bit rst;
      fe = (gap == 0);
      gap = fe ? $urandom_range(3, 12) : gap - 1;
      op = 2'($urandom_range(0, 3));
      d = (op == OP_START) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 599) == 0);
      cyc(fe, ($urandom_range(0, 3) == 0), op, 3'($urandom_range(0, 7)), d, rst);
    end

    idle(4);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
